// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared types, constants and BCD helper for score_keeper
package scoreboard_pkg;

   typedef logic [3:0] bcd_t;

   typedef enum logic {
      TEAM_A = 1'b0,
      TEAM_B = 1'b1
   } team_e;

   typedef struct packed {
      bcd_t tens;
      bcd_t ones;
   } score_t;

   localparam bcd_t       BCD_MAX_DIGIT = 4'd9;
   localparam logic [7:0] SCORE_MAX     = 8'h99;

   localparam logic [1:0] PTS_NONE  = 2'd0;
   localparam logic [1:0] PTS_ONE   = 2'd1;
   localparam logic [1:0] PTS_TWO   = 2'd2;
   localparam logic [1:0] PTS_THREE = 2'd3;

   // Adds 0..3 points to a two-digit BCD score; any carry out of the tens digit pins it at 99.
   function automatic score_t bcd_add_sat(input score_t s, input logic [1:0] pts);
      logic [4:0] ones_sum;
      score_t     res;
      ones_sum = {1'b0, s.ones} + {3'b000, pts};
      res      = s;
      if (ones_sum > {1'b0, BCD_MAX_DIGIT}) begin
         if (s.tens >= BCD_MAX_DIGIT) begin
            res = score_t'(SCORE_MAX);
         end else begin
            res.tens = s.tens + 4'd1;
            res.ones = 4'(ones_sum - 5'd10);
         end
      end else begin
         res.ones = ones_sum[3:0];
      end
      return res;
   endfunction

endpackage

// File: rtl/score_keeper_if.sv
// rtl/score_keeper_if.sv - referee button inputs and display/run outputs of score_keeper
interface score_keeper_if;
   import scoreboard_pkg::*;

   logic       btn_add_a;
   logic       btn_add_b;
   logic [1:0] pts_sel;
   logic       btn_undo;
   logic       btn_run;
   logic       btn_period;
   logic       run_en;
   bcd_t       hex_out7;
   bcd_t       hex_out6;
   bcd_t       hex_out5;
   bcd_t       hex_out4;
   bcd_t       hex_out3;
   bcd_t       hex_out2;
   bcd_t       hex_out1;
   bcd_t       hex_out0;

   modport master (
      output btn_add_a, btn_add_b, pts_sel, btn_undo, btn_run, btn_period,
      input  run_en, hex_out7, hex_out6, hex_out5, hex_out4,
             hex_out3, hex_out2, hex_out1, hex_out0
   );

   modport slave (
      input  btn_add_a, btn_add_b, pts_sel, btn_undo, btn_run, btn_period,
      output run_en, hex_out7, hex_out6, hex_out5, hex_out4,
             hex_out3, hex_out2, hex_out1, hex_out0
   );

endinterface

// File: rtl/score_keeper_key_debounce.sv
// rtl/score_keeper_key_debounce.sv - button synchroniser, stability counter and press pulse
module key_debounce #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_btn,
   output logic o_press
);

   localparam int             CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_press;
   logic [CNT_W-1:0] r_cnt;

   // The counter only advances while the synchronised level disagrees with the accepted one.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= r_sync2;
            r_press <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/score_keeper.sv
// rtl/score_keeper.sv - debounced referee buttons driving BCD scores, period and run flag
module score_keeper
   import scoreboard_pkg::*;
#(
   parameter int DEB_CYCLES = 1_000_000,
   parameter int MAX_PERIOD = 4
) (
   input logic           sys_clk,
   input logic           sys_rst,
   score_keeper_if.slave bus
);

   localparam logic [3:0] PERIOD_LAST = 4'(MAX_PERIOD);

   logic [4:0] w_raw;
   logic [4:0] w_press;
   logic       w_add_a;
   logic       w_add_b;

   score_t     r_score_a;
   score_t     r_score_b;
   score_t     r_hist_score;
   team_e      r_hist_team;
   logic       r_hist_valid;
   logic       r_run;
   logic [3:0] r_period;

   assign w_raw = {bus.btn_period, bus.btn_run, bus.btn_undo, bus.btn_add_b, bus.btn_add_a};

   for (genvar g = 0; g < 5; g++) begin : g_deb
      key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
         .i_clk   (sys_clk),
         .i_rst   (sys_rst),
         .i_btn   (w_raw[g]),
         .o_press (w_press[g])
      );
   end

   assign w_add_a = w_press[0] && (bus.pts_sel != PTS_NONE);
   assign w_add_b = w_press[1] && (bus.pts_sel != PTS_NONE);

   // Later assignments win: B over A in the history, add over undo, period over run and history.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_score_a    <= '0;
         r_score_b    <= '0;
         r_hist_score <= '0;
         r_hist_team  <= TEAM_A;
         r_hist_valid <= 1'b0;
         r_run        <= 1'b0;
         r_period     <= 4'd1;
      end else begin
         if (w_add_a) begin
            r_score_a <= bcd_add_sat(r_score_a, bus.pts_sel);
         end
         if (w_add_b) begin
            r_score_b <= bcd_add_sat(r_score_b, bus.pts_sel);
         end

         if (w_add_b) begin
            r_hist_team  <= TEAM_B;
            r_hist_score <= r_score_b;
            r_hist_valid <= 1'b1;
         end else if (w_add_a) begin
            r_hist_team  <= TEAM_A;
            r_hist_score <= r_score_a;
            r_hist_valid <= 1'b1;
         end else if (w_press[2] && r_hist_valid) begin
            if (r_hist_team == TEAM_B) begin
               r_score_b <= r_hist_score;
            end else begin
               r_score_a <= r_hist_score;
            end
            r_hist_valid <= 1'b0;
         end

         if (w_press[4]) begin
            if (r_period < PERIOD_LAST) begin
               r_period <= r_period + 4'd1;
            end
            r_run        <= 1'b0;
            r_hist_valid <= 1'b0;
         end else if (w_press[3]) begin
            r_run <= ~r_run;
         end
      end
   end

   assign bus.run_en   = r_run;
   assign bus.hex_out7 = r_period;
   assign bus.hex_out6 = {3'b000, r_run};
   assign bus.hex_out5 = 4'd0;
   assign bus.hex_out4 = 4'd0;
   assign bus.hex_out3 = r_score_a.tens;
   assign bus.hex_out2 = r_score_a.ones;
   assign bus.hex_out1 = r_score_b.tens;
   assign bus.hex_out0 = r_score_b.ones;

endmodule

// File: tb/tb_score_keeper.sv
// tb/tb_score_keeper.sv - scoreboard bench for score_keeper
`timescale 1ns/1ps
module tb_score_keeper;
   import scoreboard_pkg::*;

   localparam int DEB  = 4;
   localparam int MAXP = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   score_keeper_if bus();

   score_keeper #(.DEB_CYCLES(DEB), .MAX_PERIOD(MAXP)) dut (
      .sys_clk (clk),
      .sys_rst (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] hex;
      logic        run;
   } exp_t;

   exp_t sb[$];

   int n_checks  = 0;
   int n_errors  = 0;
   int n_changes = 0;

   int m_a, m_b, m_period, m_run, m_hist_valid, m_hist_team, m_hist_val;

   logic [32:0] prev_obs = '0;

   function automatic logic [31:0] get_hex();
      return {bus.hex_out7, bus.hex_out6, bus.hex_out5, bus.hex_out4,
              bus.hex_out3, bus.hex_out2, bus.hex_out1, bus.hex_out0};
   endfunction

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [31:0] exp_hex();
      return {4'(m_period), 4'(m_run), 8'h00, to_bcd(m_a), to_bcd(m_b)};
   endfunction

   always @(negedge clk) begin
      if ({bus.run_en, get_hex()} !== prev_obs) n_changes++;
      prev_obs = {bus.run_en, get_hex()};
   end

   task automatic model_reset();
      m_a = 0; m_b = 0; m_period = 1; m_run = 0;
      m_hist_valid = 0; m_hist_team = 0; m_hist_val = 0;
   endtask

   // mask bits: 0 add_a, 1 add_b, 2 undo, 3 run, 4 period
   task automatic model_apply(input logic [4:0] mask);
      int p;
      int old_a;
      int old_b;
      p = int'(bus.pts_sel);
      old_a = m_a;
      old_b = m_b;
      if (mask[0] && p != 0) m_a = (m_a + p > 99) ? 99 : m_a + p;
      if (mask[1] && p != 0) m_b = (m_b + p > 99) ? 99 : m_b + p;
      if (mask[1] && p != 0) begin
         m_hist_valid = 1; m_hist_team = 1; m_hist_val = old_b;
      end else if (mask[0] && p != 0) begin
         m_hist_valid = 1; m_hist_team = 0; m_hist_val = old_a;
      end else if (mask[2] && m_hist_valid != 0) begin
         if (m_hist_team == 1) m_b = m_hist_val; else m_a = m_hist_val;
         m_hist_valid = 0;
      end
      if (mask[4]) begin
         if (m_period < MAXP) m_period++;
         m_run = 0;
         m_hist_valid = 0;
      end else if (mask[3]) begin
         m_run = 1 - m_run;
      end
   endtask

   task automatic set_btns(input logic [4:0] mask);
      {bus.btn_period, bus.btn_run, bus.btn_undo, bus.btn_add_b, bus.btn_add_a} = mask;
   endtask

   task automatic press(input logic [4:0] mask, input string name);
      exp_t e;
      @(negedge clk);
      set_btns(mask);
      model_apply(mask);
      sb.push_back('{name, exp_hex(), m_run[0]});
      repeat (10) @(negedge clk);
      set_btns(5'b0);
      repeat (12) @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if ({bus.run_en, get_hex()} !== {e.run, e.hex}) begin
         n_errors++;
         $display("FAIL %s: got hex=%h run=%b, expected hex=%h run=%b",
                  e.name, get_hex(), bus.run_en, e.hex, e.run);
      end
   endtask

   task automatic test_reset();
      set_btns(5'b0);
      bus.pts_sel = 2'd0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (5) @(negedge clk);
      n_checks++;
      if ({bus.run_en, get_hex()} !== {1'b0, 32'h1000_0000}) begin
         n_errors++;
         $display("FAIL reset_state: got hex=%h run=%b, expected hex=10000000 run=0",
                  get_hex(), bus.run_en);
      end
   endtask

   task automatic test_add_a();
      exp_t e;
      int   n0;
      int   lat;
      bit   seen;
      n0 = n_changes;
      bus.pts_sel = 2'd3;
      @(negedge clk);
      bus.btn_add_a = 1'b1;
      model_apply(5'b00001);
      sb.push_back('{"add_a_first", exp_hex(), m_run[0]});
      lat = 0;
      seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (get_hex() !== prev_obs[31:0]) seen = 1;
      end
      n_checks++;
      if (!seen || lat != DEB + 3) begin
         n_errors++;
         $display("FAIL press_latency: got %0d cycles (seen=%0d), expected %0d", lat, seen, DEB + 3);
      end
      repeat (8) @(negedge clk);
      bus.btn_add_a = 1'b0;
      repeat (12) @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (get_hex() !== e.hex) begin
         n_errors++;
         $display("FAIL %s: got hex=%h, expected hex=%h", e.name, get_hex(), e.hex);
      end
      press(5'b00001, "add_a_3_second");
      press(5'b00001, "add_a_3_third");
      bus.pts_sel = 2'd2;
      press(5'b00001, "add_a_2");
      n_checks++;
      if (n_changes - n0 != 4) begin
         n_errors++;
         $display("FAIL add_a_update_count: got %0d updates, expected 4", n_changes - n0);
      end
      n_checks++;
      if ({bus.hex_out3, bus.hex_out2} !== 8'h11) begin
         n_errors++;
         $display("FAIL score_a_11: got %h, expected 11", {bus.hex_out3, bus.hex_out2});
      end
   endtask

   task automatic test_saturate();
      bus.pts_sel = 2'd3;
      for (int i = 0; i < 29; i++) press(5'b00001, "preload_a");
      press(5'b00001, "a_98_plus_3");
      n_checks++;
      if ({bus.hex_out3, bus.hex_out2} !== 8'h99) begin
         n_errors++;
         $display("FAIL score_a_sat: got %h, expected 99", {bus.hex_out3, bus.hex_out2});
      end
      press(5'b00001, "a_99_stays");
   endtask

   task automatic test_undo();
      bus.pts_sel = 2'd3;
      for (int i = 0; i < 15; i++) press(5'b00010, "preload_b");
      bus.pts_sel = 2'd2;
      press(5'b00010, "b_45_plus_2");
      bus.pts_sel = 2'd0;
      press(5'b00001, "pts_zero_ignored");
      press(5'b00100, "undo_b");
      n_checks++;
      if ({bus.hex_out1, bus.hex_out0} !== 8'h45) begin
         n_errors++;
         $display("FAIL undo_b_45: got %h, expected 45", {bus.hex_out1, bus.hex_out0});
      end
      press(5'b00100, "undo_again_noop");
   endtask

   task automatic test_back_to_back();
      bus.pts_sel = 2'd1;
      press(5'b00011, "both_add");
      press(5'b00100, "undo_after_both");
   endtask

   task automatic test_run_bounce();
      int n0;
      n0 = n_changes;
      for (int g = 1; g <= 3; g++) begin
         @(negedge clk);
         bus.btn_run = 1'b1;
         repeat (g) @(negedge clk);
         bus.btn_run = 1'b0;
         repeat (5) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      n_checks++;
      if (n_changes != n0 || bus.run_en !== 1'b0) begin
         n_errors++;
         $display("FAIL glitch_reject: got %0d updates run=%b, expected 0 updates run=0",
                  n_changes - n0, bus.run_en);
      end
      press(5'b01000, "run_toggle");
      n_checks++;
      if (n_changes - n0 != 1 || bus.hex_out6 !== 4'd1) begin
         n_errors++;
         $display("FAIL run_single_toggle: got %0d updates hex6=%h, expected 1 update hex6=1",
                  n_changes - n0, bus.hex_out6);
      end
   endtask

   task automatic test_period();
      bus.pts_sel = 2'd1;
      press(5'b00010, "add_b_before_period");
      for (int i = 0; i < 5; i++) press(5'b10000, "period_step");
      n_checks++;
      if (bus.hex_out7 !== 4'(MAXP) || bus.run_en !== 1'b0) begin
         n_errors++;
         $display("FAIL period_sat: got period=%h run=%b, expected period=%0d run=0",
                  bus.hex_out7, bus.run_en, MAXP);
      end
      press(5'b00100, "undo_after_period");
   endtask

   task automatic test_reset_mid_debounce();
      bus.pts_sel = 2'd3;
      @(negedge clk);
      bus.btn_add_a = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      bus.btn_add_a = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      repeat (20) @(negedge clk);
      n_checks++;
      if ({bus.run_en, get_hex()} !== {m_run[0], exp_hex()}) begin
         n_errors++;
         $display("FAIL reset_mid_debounce: got hex=%h run=%b, expected hex=%h run=0",
                  get_hex(), bus.run_en, exp_hex());
      end
   endtask

   initial begin
      test_reset();
      test_add_a();
      test_saturate();
      test_undo();
      test_back_to_back();
      test_run_bounce();
      test_period();
      test_reset_mid_debounce();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
